// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: 16 single-cycle base ops plus iterative
// unsigned/signed multiply and restoring unsigned divide, with ZNCV flags.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic [3:0]       flags,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  localparam logic [4:0] OP_ADD   = 5'h00, OP_ADDX = 5'h01, OP_SUB  = 5'h02, OP_SUBX = 5'h03;
  localparam logic [4:0] OP_AND   = 5'h04, OP_OR   = 5'h05, OP_XOR  = 5'h06, OP_XNOR = 5'h07;
  localparam logic [4:0] OP_ANDN  = 5'h08, OP_ORN  = 5'h09, OP_SLL  = 5'h0A, OP_SRL  = 5'h0B;
  localparam logic [4:0] OP_SRA   = 5'h0C, OP_PASSA = 5'h0D, OP_PASSB = 5'h0E, OP_NOTB = 5'h0F;
  localparam logic [4:0] OP_UMUL  = 5'h10, OP_SMUL = 5'h11, OP_UDIV = 5'h12;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [WIDTH-1:0]  opa_reg, opb_reg, hi_reg, lo_reg;
  logic              smul_reg, dz_reg;

  logic              accept, is_mul, is_div;
  logic [WIDTH-1:0]  base_y;
  logic              base_c, base_v;
  logic [WIDTH:0]    sum_ext;
  logic [WIDTH:0]    mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0]  mul_hi_fix, div_y, div_hi;

  assign in_ready = (state_reg == IDLE) || (state_reg == DONE);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (opcode == OP_UMUL) || (opcode == OP_SMUL);
  assign is_div   = (opcode == OP_UDIV);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (accept && is_mul)      state_next = MUL;
        else if (accept && is_div) state_next = DIV;
      end
      MUL, DIV: if (cnt_reg == CNT_LAST) state_next = DONE;
      default:  state_next = IDLE;
    endcase
  end

  // Single-cycle base operations, evaluated straight from the input operands.
  always_comb begin
    base_y  = a;
    base_c  = 1'b0;
    base_v  = 1'b0;
    sum_ext = '0;
    case (opcode)
      OP_ADD, OP_ADDX: begin
        sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin & (opcode == OP_ADDX)};
        base_y  = sum_ext[WIDTH-1:0];
        base_c  = sum_ext[WIDTH];
        base_v  = (a[WIDTH-1] == b[WIDTH-1]) && (base_y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SUBX: begin
        // Top bit of the (WIDTH+1)-bit difference is the borrow.
        sum_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin & (opcode == OP_SUBX)};
        base_y  = sum_ext[WIDTH-1:0];
        base_c  = sum_ext[WIDTH];
        base_v  = (a[WIDTH-1] != b[WIDTH-1]) && (base_y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   base_y = a & b;
      OP_OR:    base_y = a | b;
      OP_XOR:   base_y = a ^ b;
      OP_XNOR:  base_y = ~(a ^ b);
      OP_ANDN:  base_y = a & ~b;
      OP_ORN:   base_y = a | ~b;
      OP_SLL:   base_y = a << b[SHW-1:0];
      OP_SRL:   base_y = a >> b[SHW-1:0];
      OP_SRA:   base_y = $signed(a) >>> b[SHW-1:0];
      OP_PASSA: base_y = a;
      OP_PASSB: base_y = b;
      OP_NOTB:  base_y = ~b;
      default:  base_y = a;
    endcase
  end

  // Iteration datapath: shift-add multiply and restoring divide share hi/lo.
  always_comb begin
    mul_sum    = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opa_reg} : '0);
    div_shift  = {hi_reg, lo_reg[WIDTH-1]};
    div_trial  = div_shift - {1'b0, opb_reg};
    // Signed high word = unsigned high word minus the cross terms of negative operands.
    mul_hi_fix = hi_reg - ((smul_reg && opa_reg[WIDTH-1]) ? opb_reg : '0)
                        - ((smul_reg && opb_reg[WIDTH-1]) ? opa_reg : '0);
    div_y      = dz_reg ? '1 : lo_reg;
    div_hi     = dz_reg ? opa_reg : hi_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      smul_reg  <= 1'b0;
      dz_reg    <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      y_hi      <= '0;
      flags     <= '0;
      div_zero  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            cnt_reg  <= '0;
            opa_reg  <= a;
            opb_reg  <= b;
            hi_reg   <= '0;
            lo_reg   <= is_mul ? b : a;
            smul_reg <= (opcode == OP_SMUL);
            dz_reg   <= (b == '0);
            if (!is_mul && !is_div) begin
              y         <= base_y;
              y_hi      <= '0;
              flags     <= {base_y == '0, base_y[WIDTH-1], base_c, base_v};
              div_zero  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          if (cnt_reg == CNT_LAST) begin
            y         <= lo_reg;
            y_hi      <= mul_hi_fix;
            flags     <= {lo_reg == '0, lo_reg[WIDTH-1], 2'b00};
            div_zero  <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            hi_reg  <= mul_sum[WIDTH:1];
            lo_reg  <= {mul_sum[0], lo_reg[WIDTH-1:1]};
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DIV: begin
          if (cnt_reg == CNT_LAST) begin
            y         <= div_y;
            y_hi      <= div_hi;
            flags     <= {div_y == '0, div_y[WIDTH-1], 2'b00};
            div_zero  <= dz_reg;
            out_valid <= 1'b1;
          end else begin
            if (!div_trial[WIDTH]) begin
              hi_reg <= div_trial[WIDTH-1:0];
              lo_reg <= {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
              hi_reg <= div_shift[WIDTH-1:0];
              lo_reg <= {lo_reg[WIDTH-2:0], 1'b0};
            end
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a 32-bit and an 8-bit instance, expected
// results queued at issue and compared (including latency) at out_valid.
module tb_alu_mc;

  typedef struct {
    logic [31:0] y;
    logic [31:0] yh;
    logic [3:0]  f;
    logic        dz;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vec_cnt = 0;
  int   miscmp_cnt = 0;
  int   pulses32 = 0;

  exp_t q32[$];
  exp_t q8[$];

  logic        in_valid32 = 1'b0, in_ready32, cin32 = 1'b0, out_valid32, div_zero32;
  logic [4:0]  opcode32 = '0;
  logic [31:0] a32 = '0, b32 = '0, y32, y_hi32;
  logic [3:0]  flags32;

  logic        in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, out_valid8, div_zero8;
  logic [4:0]  opcode8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, y8, y_hi8;
  logic [3:0]  flags8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .opcode(opcode32), .a(a32), .b(b32), .cin(cin32), .out_valid(out_valid32),
    .y(y32), .y_hi(y_hi32), .flags(flags32), .div_zero(div_zero32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .opcode(opcode8), .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8),
    .y(y8), .y_hi(y_hi8), .flags(flags8), .div_zero(div_zero8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model32(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin);
    exp_t e;
    longint unsigned ua, ub, r, ci;
    longint sa, sb, sr;
    logic signed [31:0] as32;
    logic [63:0] p;
    logic c, v;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    as32 = a;
    c = 1'b0;
    v = 1'b0;
    e.yh = '0;
    e.dz = 1'b0;
    e.y  = a;
    ci = (op == 5'h01 || op == 5'h03) ? {63'd0, cin} : 64'd0;
    case (op)
      5'h00, 5'h01: begin
        r = ua + ub + ci; e.y = r[31:0]; c = r[32];
        sr = sa + sb + longint'(ci);
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      5'h02, 5'h03: begin
        r = ua - ub - ci; e.y = r[31:0]; c = (ua < ub + ci);
        sr = sa - sb - longint'(ci);
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      5'h04: e.y = a & b;
      5'h05: e.y = a | b;
      5'h06: e.y = a ^ b;
      5'h07: e.y = ~(a ^ b);
      5'h08: e.y = a & ~b;
      5'h09: e.y = a | ~b;
      5'h0A: e.y = a << b[4:0];
      5'h0B: e.y = a >> b[4:0];
      5'h0C: e.y = as32 >>> b[4:0];
      5'h0E: e.y = b;
      5'h0F: e.y = ~b;
      5'h10: begin p = ua * ub; e.y = p[31:0]; e.yh = p[63:32]; end
      5'h11: begin p = sa * sb; e.y = p[31:0]; e.yh = p[63:32]; end
      5'h12: begin
        if (b == 32'd0) begin e.y = 32'hFFFFFFFF; e.yh = a; e.dz = 1'b1; end
        else begin e.y = a / b; e.yh = a % b; end
      end
      default: e.y = a;
    endcase
    e.f = {e.y == 32'd0, e.y[31], c, v};
    e.due = 0;
    return e;
  endfunction

  task automatic issue32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready32 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready32) check("ready32_timeout", 64'd0, 64'd1);
    opcode32 = op; a32 = a; b32 = b; cin32 = cin; in_valid32 = 1'b1;
    e = model32(op, a, b, cin);
    e.due = cyc + 1 + ((op inside {5'h10, 5'h11, 5'h12}) ? 33 : 0);
    q32.push_back(e);
    @(posedge clk);
    #1 in_valid32 = 1'b0;
  endtask

  task automatic issue8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ey, input logic [7:0] eyh, input logic [3:0] ef,
                        input int lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready8 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready8) check("ready8_timeout", 64'd0, 64'd1);
    opcode8 = op; a8 = a; b8 = b; cin8 = 1'b0; in_valid8 = 1'b1;
    e.y = {24'd0, ey}; e.yh = {24'd0, eyh}; e.f = ef; e.dz = 1'b0;
    e.due = cyc + 1 + lat;
    q8.push_back(e);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst && out_valid32) begin
      pulses32++;
      if (q32.size() == 0) check("unexpected_out32", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        $display("w32 cyc=%0d y=%h y_hi=%h flags=%b dz=%b", cyc, y32, y_hi32, flags32, div_zero32);
        check("y32", {32'd0, y32}, {32'd0, e.y});
        check("y_hi32", {32'd0, y_hi32}, {32'd0, e.yh});
        check("flags32", {60'd0, flags32}, {60'd0, e.f});
        check("div_zero32", {63'd0, div_zero32}, {63'd0, e.dz});
        check("latency32", 64'(cyc), 64'(e.due));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst && out_valid8) begin
      if (q8.size() == 0) check("unexpected_out8", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        $display("w8  cyc=%0d y=%h y_hi=%h flags=%b dz=%b", cyc, y8, y_hi8, flags8, div_zero8);
        check("y8", {56'd0, y8}, {32'd0, e.y});
        check("y_hi8", {56'd0, y_hi8}, {32'd0, e.yh});
        check("flags8", {60'd0, flags8}, {60'd0, e.f});
        check("latency8", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 300) begin @(negedge clk); n++; end
    if (q32.size() != 0 || q8.size() != 0) check("drain_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_y", {32'd0, y32}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid32}, 64'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("rst_in_ready", {63'd0, in_ready32}, 64'd1);

    // Overflow / borrow cases issued back-to-back.
    issue32(5'h00, 32'h7FFFFFFF, 32'd1, 1'b0);
    issue32(5'h02, 32'd0, 32'd1, 1'b0);
    issue32(5'h08, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    issue32(5'h0C, 32'h80000000, 32'h24, 1'b0);
    issue32(5'h01, 32'hFFFFFFFF, 32'd0, 1'b1);
    issue32(5'h03, 32'h80000000, 32'd0, 1'b1);
    issue32(5'h17, 32'h12345678, 32'h9, 1'b0);
    for (int i = 0; i < 16; i++)
      issue32(5'(i), $urandom, $urandom, 1'($urandom_range(0, 1)));

    // SMUL with busy-time requests that must be ignored.
    issue32(5'h11, 32'hFFFFFFFE, 32'd3, 1'b0);
    @(negedge clk);
    check("busy_in_ready", {63'd0, in_ready32}, 64'd0);
    opcode32 = 5'h00; a32 = 32'd1; b32 = 32'd1; in_valid32 = 1'b1;
    repeat (3) @(negedge clk);
    in_valid32 = 1'b0;
    issue32(5'h10, 32'hFFFFFFFE, 32'd3, 1'b0);
    issue32(5'h12, 32'd100, 32'd7, 1'b0);
    issue32(5'h12, 32'd5, 32'd0, 1'b0);
    issue32(5'h12, $urandom, 32'($urandom_range(1, 1000)), 1'b0);
    issue32(5'h11, $urandom, $urandom, 1'b0);
    issue32(5'h00, 32'd3, 32'd4, 1'b0);

    issue8(5'h10, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0000, 9);
    issue8(5'h15, 8'h9C, 8'h11, 8'h9C, 8'h00, 4'b0100, 0);
    issue8(5'h00, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0101, 0);
    issue8(5'h12, 8'd200, 8'd7, 8'd28, 8'd4, 4'b0000, 9);
    drain();

    // Reset five cycles into a multiply: no result may ever appear.
    issue32(5'h10, 32'd7, 32'd9, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_y", {32'd0, y32}, 64'd0);
    check("midrst_y_hi", {32'd0, y_hi32}, 64'd0);
    check("midrst_flags", {60'd0, flags32}, 64'd0);
    check("midrst_out_valid", {63'd0, out_valid32}, 64'd0);
    q32.delete();
    p0 = pulses32;
    @(negedge clk) rst = 1'b0;
    #1 check("midrst_in_ready", {63'd0, in_ready32}, 64'd1);
    repeat (40) @(negedge clk);
    check("midrst_no_pulse", 64'(pulses32), 64'(p0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered successor to the combinational integer ALU.
- Executes the 16 base ALU operations in one cycle.
- Adds iterative unsigned/signed multiply and unsigned divide, each taking WIDTH iterations.
- Sits between the operand-select stage and writeback, with a valid/ready input handshake and a registered result and ZNCV flags.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range ≥ 4, power of two.
- SHW, $clog2(WIDTH), number of low bits of b used as the shift amount.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- in_valid  input  1  operation request.
- in_ready  output  1  high when the block can accept a request (state IDLE).
- opcode  input  5  operation select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry/borrow in for ADDX/SUBX.
- out_valid  output  1  one-cycle pulse when y, y_hi, flags and div_zero are updated.
- y  output  WIDTH  result, product low word, or quotient.
- y_hi  output  WIDTH  product high word or remainder; 0 for base ops.
- flags  output  4  {Z,N,C,V}.
- div_zero  output  1  set with the result when UDIV has b==0; else 0.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; in_ready=1 after reset release; out_valid=0; y=0; y_hi=0; flags=0; div_zero=0; iteration counter=0. Reset mid-operation aborts the operation and produces no result pulse.
- Handshake:
  - Accept on a rising edge with in_valid && in_ready.
  - a, b, cin and opcode are captured at acceptance; later input changes have no effect.
  - in_valid while in_ready=0 is ignored, not queued.
- Outputs: y, y_hi, flags and div_zero hold their last values between out_valid pulses.
- Base ops (opcode[4]=0), latency 1: out_valid is high in the cycle after acceptance; in_ready stays 1, so back-to-back issue is supported.
  - 00 ADD: a+b.
  - 01 ADDX: a+b+cin.
  - 02 SUB: a-b.
  - 03 SUBX: a-b-cin.
  - 04 AND: a&b (bitwise).
  - 05 OR: a|b.
  - 06 XOR: a^b.
  - 07 XNOR: ~(a^b).
  - 08 ANDN: a&~b (bitwise).
  - 09 ORN: a|~b.
  - 0A SLL: a<<b[SHW-1:0].
  - 0B SRL: a>>b[SHW-1:0].
  - 0C SRA: arithmetic right shift by b[SHW-1:0].
  - 0D PASSA: a.
  - 0E PASSB: b.
  - 0F NOTB: ~b.
- Extended ops:
  - 10 UMUL and 11 SMUL: {y_hi,y} = full 2*WIDTH product. SMUL treats both operands as two's complement.
  - 12 UDIV: y = a/b, y_hi = a%b.
  - 13–1F: reserved; execute as PASSA with latency 1.
- Flags, computed from the WIDTH-bit y for every op:
  - Z = (y==0).
  - N = y[WIDTH-1].
  - ADD/ADDX: C = carry out of bit WIDTH-1; V = signed overflow (operands same sign, result sign differs).
  - SUB/SUBX: C = borrow (1 when the unsigned a < b + cin); V = signed overflow of subtraction.
  - All other ops: C=0, V=0.
- FSM states:
  - IDLE: accepting a base op stays in IDLE; accepting 10/11 goes to MUL; accepting 12 goes to DIV.
  - MUL: shift-add, one partial product per cycle. After WIDTH cycles go to DONE. SMUL applies sign correction so the result equals the signed product.
  - DIV: restoring division, one quotient bit per cycle. After WIDTH cycles go to DONE.
  - DONE: registers the result; out_valid=1; in_ready=1, so a new request can be accepted this cycle. Next state is IDLE, or MUL/DIV if an extended op is accepted.
- Multi-cycle latency: out_valid rises WIDTH+1 cycles after the acceptance edge; in_ready=0 in MUL and DIV.
- Divide by zero: same latency as a normal divide; y = all ones, y_hi = a, div_zero=1, flags Z=0, N=1, C=0, V=0.
- Counter: log2(WIDTH)+1 bits, cleared on acceptance; wrap-around is not used.

Test Plan:
- Reset asserted mid-MUL (WIDTH=32, a=7, b=9, reset at cycle 5 after acceptance) → outputs clear immediately; no out_valid; in_ready=1 after release.
- ADD a=0x7FFFFFFF, b=1 → next cycle y=0x80000000, flags=0101 (N,V). SUB a=0, b=1 → y=0xFFFFFFFF, flags=0110 (N,C). Issued back-to-back → two consecutive out_valid pulses.
- ANDN a=0xF0F0F0F0, b=0xFF00FF00 → y=0x00F000F0, flags=0000. SRA a=0x80000000, b=0x24 (shift 4) → y=0xF8000000, flags=0100.
- SMUL a=0xFFFFFFFE (-2), b=3 → out_valid exactly 33 cycles after acceptance, y=0xFFFFFFFA, y_hi=0xFFFFFFFF, N=1. UMUL with the same operands → y_hi=0x00000002, y=0xFFFFFFFA. in_valid pulsed while busy is ignored.
- UDIV a=100, b=7 → y=14, y_hi=2, div_zero=0. UDIV a=5, b=0 → y=0xFFFFFFFF, y_hi=5, div_zero=1.
- WIDTH=8 instance: UMUL a=0xFF, b=0xFF → y_hi=0xFE, y=0x01, out_valid 9 cycles after acceptance. Opcode 0x15 → PASSA with latency 1.
